// File: rtl/aidc_lite_pkg.sv
// Shared constants, pointer types and the beat half-select helper for the
// compressor output buffer.
package aidc_lite_pkg;

    localparam int AIDC_LITE_BLK_WORDS = 8;
    localparam int AIDC_LITE_RD_BEATS  = 16;

    typedef logic        bank_idx_t;
    typedef logic [2:0]  wr_ptr_t;
    typedef logic [3:0]  rd_ptr_t;
    typedef logic [63:0] word_t;
    typedef logic [31:0] beat_t;

    localparam wr_ptr_t WP_LAST = wr_ptr_t'(AIDC_LITE_BLK_WORDS - 1);
    localparam rd_ptr_t RP_LAST = rd_ptr_t'(AIDC_LITE_RD_BEATS - 1);

    // Upper half is served first to match the engine's packing order.
    function automatic beat_t half_sel(input word_t w, input logic lo);
        return lo ? w[31:0] : w[63:32];
    endfunction

endpackage

// File: rtl/aidc_lite_comp_out_buf_if.sv
// Compressor write port and engine read port of the output buffer.
// master = compressor/engine side, slave = buffer.
interface aidc_lite_comp_out_buf_if;
    import aidc_lite_pkg::*;

    logic  wr_en_i;
    logic  wr_sop_i;
    logic  wr_eop_i;
    word_t wr_data_i;
    logic  ready_o;
    logic  rden_i;
    beat_t rdata_o;
    logic  ovf_o;
    logic  unf_o;
    logic  clr_i;

    modport master (
        output wr_en_i, wr_sop_i, wr_eop_i, wr_data_i, rden_i, clr_i,
        input  ready_o, rdata_o, ovf_o, unf_o
    );

    modport slave (
        input  wr_en_i, wr_sop_i, wr_eop_i, wr_data_i, rden_i, clr_i,
        output ready_o, rdata_o, ovf_o, unf_o
    );

endinterface

// File: rtl/aidc_lite_out_bank.sv
// One 8x64 block bank: storage with zero-fill above a short block's eop word,
// the bank full flag and the 32-bit show-ahead half-select read mux.
module aidc_lite_out_bank
    import aidc_lite_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    we,
    input  wr_ptr_t waddr,
    input  logic    weop,
    input  word_t   wdata,
    input  logic    set_full,
    input  logic    clr_full,
    input  rd_ptr_t rp,
    output logic    full,
    output beat_t   rdata
);

    word_t mem [AIDC_LITE_BLK_WORDS];

    // Storage is deliberately not reset; an eop word clears every slot above it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < AIDC_LITE_BLK_WORDS; i++) begin
            if (we && (wr_ptr_t'(i) == waddr))
                mem[i] <= wdata;
            else if (we && weop && (wr_ptr_t'(i) > waddr))
                mem[i] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            full <= 1'b0;
        else if (set_full)
            full <= 1'b1;
        else if (clr_full)
            full <= 1'b0;
    end

    assign rdata = half_sel(mem[rp[3:1]], rp[0]);

endmodule

// File: rtl/aidc_lite_comp_out_buf.sv
// Write-back buffer: collects 8x64-bit compressed words per block and serves
// them as 16 show-ahead 32-bit beats. AIDC_LITE_OUT_BUF_PINGPONG_EN adds a second bank.
module aidc_lite_comp_out_buf
    import aidc_lite_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    aidc_lite_comp_out_buf_if.slave bus
);

`ifdef AIDC_LITE_OUT_BUF_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    wr_ptr_t wp;
    wr_ptr_t wr_addr;
    rd_ptr_t rp;
    logic    fill_full;
    logic    drain_full;
    beat_t   rdata_sel;
    logic    wr_acc;
    logic    wr_done;
    logic    rd_acc;
    logic    rd_last;
    logic    ovf;
    logic    unf;

    logic    full       [NUM_BANKS];
    beat_t   bank_rdata [NUM_BANKS];
    logic    bank_we    [NUM_BANKS];
    logic    bank_set   [NUM_BANKS];
    logic    bank_clr   [NUM_BANKS];

    // A full fill bank drops the word, even if that bank is freed this same cycle.
    always_comb begin
        wr_addr = bus.wr_sop_i ? '0 : wp;
        wr_acc  = bus.wr_en_i && !fill_full;
        wr_done = wr_acc && (bus.wr_eop_i || (wr_addr == WP_LAST));
        rd_acc  = bus.rden_i && drain_full;
        rd_last = rd_acc && (rp == RP_LAST);
    end

`ifdef AIDC_LITE_OUT_BUF_PINGPONG_EN
    bank_idx_t fb;
    bank_idx_t db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb <= 1'b0;
            db <= 1'b0;
        end else begin
            if (wr_done)
                fb <= ~fb;
            if (rd_last)
                db <= ~db;
        end
    end

    always_comb begin
        fill_full  = full[fb];
        drain_full = full[db];
        rdata_sel  = bank_rdata[db];
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b]  = wr_acc  && (fb == bank_idx_t'(b));
            bank_set[b] = wr_done && (fb == bank_idx_t'(b));
            bank_clr[b] = rd_last && (db == bank_idx_t'(b));
        end
    end
`else
    always_comb begin
        fill_full   = full[0];
        drain_full  = full[0];
        rdata_sel   = bank_rdata[0];
        bank_we[0]  = wr_acc;
        bank_set[0] = wr_done;
        bank_clr[0] = rd_last;
    end
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        aidc_lite_out_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (bank_we[b]),
            .waddr    (wr_addr),
            .weop     (bus.wr_eop_i),
            .wdata    (bus.wr_data_i),
            .set_full (bank_set[b]),
            .clr_full (bank_clr[b]),
            .rp       (rp),
            .full     (full[b]),
            .rdata    (bank_rdata[b])
        );
    end

    // clr_i wins over a same-cycle overflow/underflow event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wr_acc)
                wp <= wr_done ? '0 : wr_addr + 1'b1;
            if (rd_acc)
                rp <= rp + 1'b1;
            if (bus.clr_i)
                ovf <= 1'b0;
            else if (bus.wr_en_i && fill_full)
                ovf <= 1'b1;
            if (bus.clr_i)
                unf <= 1'b0;
            else if (bus.rden_i && !drain_full)
                unf <= 1'b1;
        end
    end

    assign bus.ready_o = drain_full;
    assign bus.rdata_o = rdata_sel;
    assign bus.ovf_o   = ovf;
    assign bus.unf_o   = unf;

endmodule

// File: tb/tb_aidc_lite_comp_out_buf.sv
// Bench for aidc_lite_comp_out_buf: vector table, hand-written corner sequences
// and randomized traffic against a block/beat queue model.
module tb_aidc_lite_comp_out_buf;
    import aidc_lite_pkg::*;

`ifdef AIDC_LITE_OUT_BUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    aidc_lite_comp_out_buf_if bus();

    aidc_lite_comp_out_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: completed blocks as a flat stream of 32-bit beats, plus the open block.
    logic [31:0] mq[$];
    logic [63:0] part[$];
    logic        m_ovf;
    logic        m_unf;

    typedef struct {
        logic        w, s, e;
        logic [63:0] d;
        logic        r, c;
        logic        x_rdy, x_ovf, x_unf;
        logic        chk_d;
        logic [31:0] x_d;
    } vec_t;

    vec_t tv[64];
    int   ntv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        part.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(input logic w, s, e, input logic [63:0] d, input logic r, c);
        int occ = (mq.size() + 15) / 16;
        if (r) begin
            if (occ > 0) void'(mq.pop_front());
            else m_unf = 1'b1;
        end
        if (w) begin
            if (occ < NB) begin
                if (s) part.delete();
                part.push_back(d);
                if (e || part.size() == 8) begin
                    for (int k = 0; k < 8; k++) begin
                        logic [63:0] wd;
                        wd = (k < part.size()) ? part[k] : 64'h0;
                        mq.push_back(wd[63:32]);
                        mq.push_back(wd[31:0]);
                    end
                    part.delete();
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
    endfunction

    task automatic drive(input logic w, s, e, input logic [63:0] d, input logic r, c);
        bus.wr_en_i   = w;
        bus.wr_sop_i  = s;
        bus.wr_eop_i  = e;
        bus.wr_data_i = d;
        bus.rden_i    = r;
        bus.clr_i     = c;
        model_step(w, s, e, d, r, c);
        @(posedge clk);
        @(negedge clk);
        bus.wr_en_i = 1'b0;
        bus.wr_sop_i = 1'b0;
        bus.wr_eop_i = 1'b0;
        bus.rden_i = 1'b0;
        bus.clr_i = 1'b0;
    endtask

    task automatic rd();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " ready"}, bus.ready_o, mq.size() > 0);
        chk({tag, " ovf"}, bus.ovf_o, m_ovf);
        chk({tag, " unf"}, bus.unf_o, m_unf);
        if (mq.size() > 0) chk({tag, " rdata"}, bus.rdata_o, mq[0]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic w, s, e, input logic [63:0] d, input logic r, c,
                                input logic xr, xo, xu, cd, input logic [31:0] xd);
        tv[ntv] = '{w: w, s: s, e: e, d: d, r: r, c: c,
                    x_rdy: xr, x_ovf: xo, x_unf: xu, chk_d: cd, x_d: xd};
        ntv++;
    endfunction

    function automatic logic [63:0] w1(input int k);
        return {32'h1111_1111 * (k + 1), 32'h1111_1111 * (k + 2)};
    endfunction

    function automatic logic [31:0] b1(input int b);
        return 32'h1111_1111 * (b / 2 + 1 + b % 2);
    endfunction

    function automatic logic [31:0] bs(input int b);
        if (b >= 6) return 32'h0;
        return (b % 2 == 1) ? 32'hB000_0000 + b / 2 : 32'hA000_0000 + b / 2;
    endfunction

    initial begin
        bus.wr_en_i = 1'b0;
        bus.wr_sop_i = 1'b0;
        bus.wr_eop_i = 1'b0;
        bus.wr_data_i = '0;
        bus.rden_i = 1'b0;
        bus.clr_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("reset ready", bus.ready_o, 1'b0);
        chk("reset ovf", bus.ovf_o, 1'b0);
        chk("reset unf", bus.unf_o, 1'b0);

        // Full block, 16 reads, short block, 16 reads, then underflow and clr cases.
        for (int k = 0; k < 8; k++)
            add(1, k == 0, k == 7, w1(k), 0, 0, k == 7, 0, 0, k == 7, b1(0));
        for (int j = 0; j < 16; j++)
            add(0, 0, 0, 64'h0, 1, 0, j < 15, 0, 0, j < 15, b1(j + 1));
        for (int k = 0; k < 3; k++)
            add(1, k == 0, k == 2, {32'hA000_0000 + k, 32'hB000_0000 + k}, 0, 0,
                k == 2, 0, 0, k == 2, bs(0));
        for (int j = 0; j < 16; j++)
            add(0, 0, 0, 64'h0, 1, 0, j < 15, 0, 0, j < 15, bs(j + 1));
        add(0, 0, 0, 64'h0, 1, 0, 0, 0, 1, 0, 32'h0);
        add(0, 0, 0, 64'h0, 0, 1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 64'h0, 1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < ntv; i++) begin
            drive(tv[i].w, tv[i].s, tv[i].e, tv[i].d, tv[i].r, tv[i].c);
            chk($sformatf("tv%0d ready", i), bus.ready_o, tv[i].x_rdy);
            chk($sformatf("tv%0d ovf", i), bus.ovf_o, tv[i].x_ovf);
            chk($sformatf("tv%0d unf", i), bus.unf_o, tv[i].x_unf);
            if (tv[i].chk_d) chk($sformatf("tv%0d rdata", i), bus.rdata_o, tv[i].x_d);
        end

        // Fill B while A drains.
        do_reset();
        for (int k = 0; k < 8; k++)
            drive(1, k == 0, k == 7, {32'hC000_0000 + k, 32'hD000_0000 + k}, 0, 0);
        for (int j = 0; j < 4; j++) rd();
        for (int k = 0; k < 8; k++) begin
            drive(1, k == 0, k == 7, {32'hE000_0000 + k, 32'hF000_0000 + k}, 1, 0);
            chk($sformatf("pp mid%0d ready", k), bus.ready_o, 1'b1);
        end
        for (int j = 0; j < 4; j++) begin
            rd();
            chk($sformatf("pp tail%0d ready", j), bus.ready_o, (j < 3) || (NB == 2));
        end
        chk("pp ovf", bus.ovf_o, NB == 1);
`ifdef AIDC_LITE_OUT_BUF_PINGPONG_EN
        chk("pp B beat0", bus.rdata_o, 32'hE000_0000);
        rd();
        chk("pp B beat1", bus.rdata_o, 32'hF000_0000);
`else
        rd();
        chk("sb read after drop unf", bus.unf_o, 1'b1);
`endif

        // sop after 5 words restarts the block.
        do_reset();
        for (int k = 0; k < 5; k++)
            drive(1, k == 0, 0, {32'hDEAD_0000 + k, 32'hBEEF_0000 + k}, 0, 0);
        for (int k = 0; k < 8; k++)
            drive(1, k == 0, k == 7, {32'h5A00_0000 + k, 32'h3C00_0000 + k}, 0, 0);
        chk("sop ready", bus.ready_o, 1'b1);
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("sop beat%0d", b), bus.rdata_o,
                (b % 2 == 1) ? 32'h3C00_0000 + b / 2 : 32'h5A00_0000 + b / 2);
            rd();
        end
        chk("sop ready end", bus.ready_o, 1'b0);

        // Asynchronous reset mid-drain, then a clean block.
        do_reset();
        rd();
        chk("async unf set", bus.unf_o, 1'b1);
        for (int k = 0; k < 8; k++)
            drive(1, k == 0, k == 7, {32'h7700_0000 + k, 32'h6600_0000 + k}, 0, 0);
        for (int j = 0; j < 9; j++) rd();
        chk("async pre ready", bus.ready_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async ready", bus.ready_o, 1'b0);
        chk("async unf", bus.unf_o, 1'b0);
        chk("async ovf", bus.ovf_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1, k == 0, k == 7, {32'h4400_0000 + k, 32'h2200_0000 + k}, 0, 0);
            chk_model("post-rst wr");
        end
        for (int j = 0; j < 16; j++) begin
            chk("post-rst beat", bus.rdata_o,
                (j % 2 == 1) ? 32'h2200_0000 + j / 2 : 32'h4400_0000 + j / 2);
            rd();
        end
        chk_model("post-rst end");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aidc_lite_comp_out_buf.md
# aidc_lite_comp_out_buf

Write-back buffer between the compressor datapath and the compression engine's AHB write phase. It captures each 64 B compressed block as eight 64-bit words from the compressor and signals ready. It then serves the block to the engine as sixteen 32-bit show-ahead reads, one per accepted AHB write data beat. Optional ping-pong banking lets the compressor fill block N+1 while the engine drains block N.

## Interface
- No parameters. Sizes are fixed package constants.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- wr_en_i  in  1  compressor output word valid
- wr_sop_i  in  1  first word of block; valid with wr_en_i
- wr_eop_i  in  1  last word of block; valid with wr_en_i
- wr_data_i  in  64  compressed word
- ready_o  out  1  a complete block is available to read
- rden_i  in  1  engine consumed the current 32-bit beat
- rdata_o  out  32  current beat, show-ahead
- ovf_o  out  1  sticky: write arrived with no free bank
- unf_o  out  1  sticky: rden_i asserted while ready_o low
- clr_i  in  1  pulse; clears ovf_o and unf_o

## Operation
- Each bank is 8×64 b with a per-bank full flag.
- Write side:
  - Write pointer wp[2:0] targets fill bank fb.
  - wr_en_i & wr_sop_i forces wp=0 before storing, discarding any partial fill.
  - Each accepted word is stored at wp, then wp increments.
  - The word at wp=7, or any word with wr_eop_i, marks fb full and resets wp to 0.
  - On a short block (eop before wp=7), words above the eop word read as zero, so storage beyond it is zero-filled.
  - If more than 8 words arrive with no eop, the 9th word starts a new block, with an implicit sop.
  - If fb is full when wr_en_i arrives, the word is dropped and ovf_o is set.
- Read side:
  - Read pointer rp[3:0] targets drain bank db.
  - ready_o = full[db].
  - rdata_o = rp[0]==0 ? word[rp[3:1]][63:32] : word[rp[3:1]][31:0]. Upper half goes first, matching the engine's packing order.
  - rden_i & ready_o increments rp. At rp=15 the bank is cleared (full[db]=0), rp wraps to 0, and db toggles in ping-pong mode.
  - rden_i with ready_o low sets unf_o and leaves rp unchanged.
- Simultaneous events:
  - A write completing fill of one bank and a read freeing the other bank in the same cycle are both honoured.
  - A write to bank X in the same cycle X is freed by its final read is dropped (ovf). The bank is free only from the next cycle.
- Reset (async, also mid-block): wp=0, rp=0, fb=db=0, all full=0, ovf_o=0, unf_o=0, ready_o=0. rdata_o is don't-care while ready_o=0. Storage contents are not reset.
- clr_i has priority under a same-cycle set: the flag ends 0.

## Timing
- A word accepted at edge T (the eop or 8th word) gives ready_o=1 from T+1.
- rdata_o is combinational from the registered storage and rp. It changes the cycle after each accepted rden_i.
- The final read at edge T gives ready_o=0 from T+1 in single-bank mode. In ping-pong mode, ready_o equals the other bank's full flag from T+1.
- Throughput: back-to-back rden_i is supported every cycle.
- The bank is writable again the cycle after its final read.

## Configuration
- AIDC_LITE_OUT_BUF_PINGPONG_EN
  - Defined: two banks, with fb and db toggling independently.
  - Undefined: a single bank. fb=db=0 is constant, and a write while full always sets ovf_o, so the compressor must wait for ready_o low.

## Structure
- aidc_lite_pkg holds:
  - AIDC_LITE_BLK_WORDS=8
  - AIDC_LITE_RD_BEATS=16
  - the bank-index and pointer typedefs
- Sub-module aidc_lite_out_bank holds one 8×64 array, the full flag, zero-fill-on-eop and the 32-bit half-select read mux. It is instantiated once or twice.

## Test plan
- Eight words 0x1111_1111_2222_2222 … 0x8888_8888_9999_9999 (sop first, eop last), then 16 rden_i → rdata_o sequence 0x1111_1111, 0x2222_2222 … 0x9999_9999, with ready_o dropping the cycle after the 16th read.
- Short block: 3 words ending with eop → reads 7..16 return 0x0000_0000.
- Ping-pong mode: fill block A, start draining, fill block B mid-drain → ready_o stays 1 across the boundary and the 17th read returns B word0[63:32]. In single-bank mode the same stimulus drops B and sets ovf_o.
- rden_i while empty → unf_o=1 and rp unchanged. clr_i in the same cycle as a new underflow → unf_o=0.
- sop mid-fill after 5 words, then 8 new words → the block contains only the new words.
- Assert rst_n low after 9 reads → ready_o=0 and flags 0 asynchronously. A subsequent block then reads correctly from word 0.
